response_checker: RTL

- Receiving end of the vector-application flow: takes the ISCAS-85 DUT output response each cycle and compares it against a golden expected-response store.
- Tracks the result over one full vector run: mismatch count, first failing vector index, and the accumulated failing-bit mask.
- Used to flag aging/delay-induced functional errors on a c432-class DUT (7 outputs, 31 vectors by default).
- Synthesizable; sits between the DUT outputs and the golden-vector ROM.

---
 rtl/response_checker.sv | 127 ++++++++++++
 1 files changed

// File: rtl/response_checker.sv
// Compares DUT responses against a golden expected-response store over one vector run.
// Optional MISR signature output `sig` is enabled by defining RESPONSE_CHECKER_MISR_EN.
module response_checker #(
  parameter int unsigned OUT_WIDTH  = 7,
  parameter int unsigned VEC_LENGTH = 31,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 resp_valid,
  input  logic [OUT_WIDTH-1:0] resp_data,
  output logic [ADDR_W-1:0]    exp_addr,
  input  logic [OUT_WIDTH-1:0] exp_data,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     err_count,
  output logic                 first_err_valid,
  output logic [ADDR_W-1:0]    first_err_idx,
  output logic [OUT_WIDTH-1:0] err_bits
`ifdef RESPONSE_CHECKER_MISR_EN
  ,
  output logic [OUT_WIDTH-1:0] sig
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(VEC_LENGTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0]           state_q;
  logic [1:0]           state_d;
  logic                 start_c;
  logic                 accept_c;
  logic                 last_c;
  logic                 mism_c;
  logic [OUT_WIDTH-1:0] diff_c;

  // Next-state and per-cycle event decode
  always_comb begin
    state_d  = state_q;
    start_c  = 1'b0;
    accept_c = 1'b0;
    last_c   = 1'b0;
    diff_c   = resp_data ^ exp_data;
    mism_c   = |diff_c;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          start_c = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (resp_valid) begin
          accept_c = 1'b1;
          if (exp_addr == LAST_IDX) begin
            last_c  = 1'b1;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Result registers; a start from IDLE or DONE clears everything for the new run
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_addr        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      err_bits        <= '0;
    end else if (start_c) begin
      exp_addr        <= '0;
      busy            <= 1'b1;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      err_bits        <= '0;
    end else if (accept_c) begin
      if (mism_c) begin
        if (err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
        err_bits <= err_bits | diff_c;
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_idx   <= exp_addr;
        end
      end
      if (last_c) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= ~mism_c & (err_count == '0);
      end else begin
        exp_addr <= exp_addr + ADDR_W'(1);
      end
    end
  end

`ifdef RESPONSE_CHECKER_MISR_EN
  // MISR with feedback from the two most significant bits
  always_ff @(posedge clk) begin
    if (rst || start_c) begin
      sig <= '0;
    end else if (accept_c) begin
      sig <= {sig[OUT_WIDTH-2:0], sig[OUT_WIDTH-1] ^ sig[OUT_WIDTH-2]} ^ resp_data;
    end
  end
`endif

endmodule
